// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: per-bit rise/fall detection with sticky hit maps,
// one-shot reporting of each newly hit point over a valid/ready channel.
module toggle_cover_collector #(
    parameter  int WIDTH       = 64,
    parameter  int COVER_INDEX = 0,
    parameter  int COVER_TOTAL = 28338,
    parameter  int IDX_W       = 32,
    localparam int CNT_W       = $clog2(2*WIDTH+1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] sig,
    input  logic             clear,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [IDX_W-1:0] report_index,
    output logic             report_dir,
    output logic [CNT_W-1:0] covered_count,
    output logic             all_covered
);

    localparam int PTS   = 2*WIDTH;
    localparam int SEL_W = $clog2(PTS);

    if (COVER_INDEX + PTS > COVER_TOTAL) begin : g_index_beyond_total
        // This instance's points extend past the declared global total.
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic             primed;
    logic [WIDTH-1:0] hit_rise;
    logic [WIDTH-1:0] hit_fall;
    logic [PTS-1:0]   pending;

    logic             det;
    logic [WIDTH-1:0] new_r;
    logic [WIDTH-1:0] new_f;
    logic [PTS-1:0]   new_p;
    logic             sel_any;
    logic [SEL_W-1:0] sel_idx;
    logic [PTS-1:0]   sel_oh;
    logic             take;
    logic [PTS-1:0]   pend_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++)
            c = c + CNT_W'(v[i]);
        return c;
    endfunction

    // Detection: clear wins, so toggles seen in a clear cycle never count.
    assign det   = en && primed && !clear;
    assign new_r = det ? (sig & ~prev & ~hit_rise) : '0;
    assign new_f = det ? (~sig & prev & ~hit_fall) : '0;

    always_comb begin
        new_p = '0;
        for (int b = 0; b < WIDTH; b++) begin
            new_p[2*b]   = new_r[b];
            new_p[2*b+1] = new_f[b];
        end
    end

    // Lowest pending point wins; selection looks only at registered pending.
    always_comb begin
        sel_idx = '0;
        for (int i = PTS-1; i >= 0; i--)
            if (pending[i]) sel_idx = SEL_W'(i);
    end

    assign sel_any  = |pending;
    assign sel_oh   = {{(PTS-1){1'b0}}, 1'b1} << sel_idx;
    assign take     = !clear && sel_any && ((state == IDLE) || report_ready);
    assign pend_nxt = clear ? '0 : ((pending | new_p) & ~(take ? sel_oh : '0));
    assign cnt_nxt  = clear ? '0 : covered_count + popcount(new_r) + popcount(new_f);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev          <= '0;
            primed        <= 1'b0;
            hit_rise      <= '0;
            hit_fall      <= '0;
            pending       <= '0;
            covered_count <= '0;
            all_covered   <= 1'b0;
        end else begin
            if (en) prev <= sig;
            if (clear)   primed <= 1'b0;
            else if (en) primed <= 1'b1;
            hit_rise      <= clear ? '0 : (hit_rise | new_r);
            hit_fall      <= clear ? '0 : (hit_fall | new_f);
            pending       <= pend_nxt;
            covered_count <= cnt_nxt;
            all_covered   <= (cnt_nxt == CNT_W'(PTS));
        end
    end

    // Report channel: outputs only move on a load, valid only drops on accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            report_valid <= 1'b0;
            report_index <= '0;
            report_dir   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        report_index <= IDX_W'(COVER_INDEX) + IDX_W'(sel_idx);
                        report_dir   <= sel_idx[0];
                        report_valid <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (report_ready) begin
                        if (take) begin
                            report_index <= IDX_W'(COVER_INDEX) + IDX_W'(sel_idx);
                            report_dir   <= sel_idx[0];
                        end else begin
                            report_valid <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: begin
                    report_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector (WIDTH=4, COVER_INDEX=100) with a
// scoreboard queue of expected report indices checked at each handshake.
module tb_toggle_cover_collector;

    localparam int WIDTH = 4;
    localparam int CI    = 100;
    localparam int IDX_W = 32;
    localparam int CNT_W = $clog2(2*WIDTH+1);

    logic             clock;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] sig;
    logic             clear;
    logic             report_valid;
    logic             report_ready;
    logic [IDX_W-1:0] report_index;
    logic             report_dir;
    logic [CNT_W-1:0] covered_count;
    logic             all_covered;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    toggle_cover_collector #(
        .WIDTH(WIDTH), .COVER_INDEX(CI), .COVER_TOTAL(28338), .IDX_W(IDX_W)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .sig(sig), .clear(clear),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_index(report_index), .report_dir(report_dir),
        .covered_count(covered_count), .all_covered(all_covered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #2;
    endtask

    // Scoreboard: every accepted report must match the next queued expectation.
    always @(negedge clock) begin
        if (reset && report_valid && report_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_report", int'(report_index), -1);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("report_index", int'(report_index), e);
                chk("report_dir", int'(report_dir), (e - CI) % 2);
            end
        end
    end

    initial begin
        reset = 1'b0; en = 1'b0; sig = '0; clear = 1'b0; report_ready = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_valid", report_valid, 0);
        chk("rst_count", covered_count, 0);
        chk("rst_all", all_covered, 0);
        chk("rst_index", int'(report_index), 0);
        chk("rst_dir", report_dir, 0);
        reset = 1'b1;

        // First toggle after priming, latency two cycles
        en = 1'b1; sig = 4'b0000; nxt();
        chk("prime_no_valid", report_valid, 0);
        sig = 4'b0001; exp_q.push_back(CI); nxt();
        chk("lat_t1_valid", report_valid, 0);
        chk("count_1", covered_count, 1);
        nxt();
        chk("lat_t2_valid", report_valid, 1);
        chk("lat_t2_index", int'(report_index), CI);

        // Repeated toggles on bit 0 report once per direction
        sig = 4'b0000; exp_q.push_back(CI + 1); nxt();
        sig = 4'b0001; nxt();
        sig = 4'b0000; nxt();
        sig = 4'b0001; nxt();
        sig = 4'b0000; repeat (3) nxt();
        chk("count_2", covered_count, 2);
        chk("dedup_idle", report_valid, 0);

        // Clear, re-prime, then all rises under backpressure
        clear = 1'b1; nxt();
        clear = 1'b0;
        chk("clear_count", covered_count, 0);
        chk("clear_all", all_covered, 0);
        nxt();
        report_ready = 1'b0; sig = 4'b1111;
        for (int b = 0; b < WIDTH; b++) exp_q.push_back(CI + 2*b);
        nxt();
        chk("multi_count_4", covered_count, 4);
        chk("multi_t1_valid", report_valid, 0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("bp_valid", report_valid, 1);
            chk("bp_index_stable", int'(report_index), CI);
        end
        report_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("burst_valid", report_valid, 1);
            chk("burst_index", int'(report_index), CI + 2*i);
            nxt();
        end
        chk("burst_done", report_valid, 0);

        // All falls: full coverage, then clear while a report is held
        report_ready = 1'b0; sig = 4'b0000; exp_q.push_back(CI + 1); nxt();
        chk("full_count", covered_count, 8);
        chk("full_all", all_covered, 1);
        nxt();
        chk("held_valid", report_valid, 1);
        chk("held_index", int'(report_index), CI + 1);
        clear = 1'b1; nxt();
        clear = 1'b0; sig = 4'b1111;
        chk("clr_held_valid", report_valid, 1);
        chk("clr_held_index", int'(report_index), CI + 1);
        chk("clr_count", covered_count, 0);
        chk("clr_all", all_covered, 0);
        report_ready = 1'b1; nxt();
        chk("clr_drain_idle", report_valid, 0);
        repeat (2) nxt();
        chk("post_clr_prime_valid", report_valid, 0);
        chk("post_clr_prime_count", covered_count, 0);
        sig = 4'b0000;
        for (int b = 0; b < WIDTH; b++) exp_q.push_back(CI + 2*b + 1);
        nxt();
        chk("falls_count", covered_count, 4);
        repeat (6) nxt();
        chk("falls_done", report_valid, 0);

        // Enable low: sig ignored and prev held at 0000
        en = 1'b0; sig = 4'b1111; nxt();
        sig = 4'b1010; nxt();
        sig = 4'b0101; nxt();
        chk("en0_valid", report_valid, 0);
        chk("en0_count", covered_count, 4);
        en = 1'b1; exp_q.push_back(CI); exp_q.push_back(CI + 4); nxt();
        chk("en1_count", covered_count, 6);
        repeat (4) nxt();
        chk("en1_done", report_valid, 0);
        chk("same_as_prev_count", covered_count, 6);

        // Reset during a held report
        report_ready = 1'b0; sig = 4'b1111; nxt(); nxt();
        chk("pre_rst_valid", report_valid, 1);
        chk("pre_rst_index", int'(report_index), CI + 2);
        chk("pre_rst_all", all_covered, 1);
        reset = 1'b0; #1;
        chk("mid_rst_valid", report_valid, 0);
        chk("mid_rst_count", covered_count, 0);
        chk("mid_rst_all", all_covered, 0);
        nxt();
        reset = 1'b1; report_ready = 1'b1; nxt();
        repeat (2) nxt();
        chk("post_rst_prime_valid", report_valid, 0);
        chk("post_rst_prime_count", covered_count, 0);
        sig = 4'b0000;
        for (int b = 0; b < WIDTH; b++) exp_q.push_back(CI + 2*b + 1);
        nxt();
        chk("post_rst_count", covered_count, 4);
        repeat (6) nxt();
        chk("post_rst_done", report_valid, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toggle_cover_collector.md
Name: toggle_cover_collector

Overview:
Parametrised toggle-coverage collector: watches a WIDTH-bit signal bundle and detects rising and falling transitions per bit, giving 2*WIDTH cover points. It keeps sticky hit bitmaps and reports each point exactly once, the first time it is hit. Reports leave on a valid/ready channel so the formal harness or a fuzz-feedback drain can consume them. It is the successor to the fixed-64 per-bit DPI reporter: it tracks direction, de-duplicates hits, applies backpressure and provides coverage summary outputs.

Parameters:
WIDTH, 64, number of monitored bits (1..1024)
COVER_INDEX, 0, global index of this instance's first cover point
COVER_TOTAL, 28338, total design cover points; informational, carried for consistency with the global index map
IDX_W, 32, width of report_index

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
en  in  1  sample enable; sig is ignored while low
sig  in  WIDTH  monitored signals
clear  in  1  synchronous pulse that clears coverage state
report_valid  out  1  report available
report_ready  in  1  consumer accepts report
report_index  out  IDX_W  COVER_INDEX + 2*bit + dir
report_dir  out  1  0 = rise, 1 = fall
covered_count  out  $clog2(2*WIDTH+1)  number of distinct points hit
all_covered  out  1  covered_count == 2*WIDTH

Behaviour:
- Reset (reset==0, asynchronous): prev, primed, hit_rise, hit_fall, pending and covered_count clear to 0. report_valid, report_index, report_dir and all_covered are 0. The state machine enters IDLE.
- Sampling: on each clock edge with en=1, prev <= sig and primed <= 1. With en=0, prev and primed hold.
- Priming: the first enabled sample after reset or clear only primes the block and records no toggle.
- Detection is combinational, valid only when en && primed:
  - rise = sig & ~prev
  - fall = ~sig & prev
- New-hit vectors: new_r = rise & ~hit_rise and new_f = fall & ~hit_fall.
- At the clock edge:
  - hit_rise |= new_r and hit_fall |= new_f
  - pending |= the new hits
  - covered_count += popcount(new_r) + popcount(new_f); several points may be added in one cycle
  - No overflow is possible because the maximum count is 2*WIDTH.
- A re-hit of an already-covered point has no effect.
- Point numbering: p = 2*bit + dir, so bit b rise = 2b and bit b fall = 2b+1. Pending points are selected lowest p first.
- State machine:
  - IDLE: if pending is non-zero, at the edge load report_index/report_dir from the lowest pending point, clear that pending bit, and go to SEND.
  - SEND: report_valid=1. Outputs stay stable until report_valid && report_ready. On accept, if other pending bits exist, load the next one at the same edge and stay in SEND; otherwise go to IDLE. Throughput is 1 report per cycle while ready is held high.
- Latency: a toggle visible on sig in cycle t gives report_valid=1 in cycle t+2 at the earliest, when the FSM is IDLE and no lower pending point exists.
- A pending bit set in the same cycle the encoder selects a different point is kept. Pending updates and the selection-clear are merged as (pending | new) & ~sel.
- report_valid must never drop without a handshake.
- clear=1 has priority over detection in that cycle. At the edge it zeroes hit_rise, hit_fall, pending, covered_count and primed, and toggles in the clear cycle are discarded. An in-flight report (SEND) is held until accepted, then the FSM returns to IDLE.
- all_covered is registered, derived from the next value of covered_count, and updates in the same cycle as the count.
- Reset asserted mid-transfer immediately drops report_valid and all state. No partial report survives.

Test Plan:
- WIDTH=4, COVER_INDEX=100, report_ready=1. Reset, prime with sig=0000, then sig=0001 → one report, index 100 dir 0, 2 cycles later; covered_count=1.
- sig 0001→0000→0001→0000, ready=1 → exactly two reports (100 rise, 101 fall); repeated toggles give no more reports; covered_count=2.
- After priming at 0000, drive sig=1111 with ready=0 for 5 cycles:
  - report_valid=1 with index 100, stable; covered_count=4
  - then ready=1 → indices 100, 102, 104, 106 on consecutive cycles, then report_valid=0
- Toggle all bits both ways → covered_count=8 and all_covered=1. Then pulse clear while a report is pending: the held report completes, count returns to 0, all_covered=0, and the first post-clear sample primes only.
- en=0 while sig toggles → no reports and prev holds. en=1 with sig equal to the held prev → no report.
- Assert reset (0) while report_valid=1 → report_valid=0 immediately, covered_count=0; after release the first sample primes only.
